// File: rtl/rv32_trap_pc_ctrl.sv
// Next-PC and trap-redirect unit for the barrel-threaded core: per-hart pending
// interrupt vector FIFO plus a return-PC stack so nested traps and mret resolve in order.
module rv32_trap_pc_ctrl #(
    parameter int NUM_HARTS  = 8,
    parameter int PC_W       = 32,
    parameter int IRQ_DEPTH  = 4,
    parameter int NEST_DEPTH = 2,
    localparam int HID_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_HARTS-1:0]      irq_valid_i,
    input  logic [NUM_HARTS*PC_W-1:0] irq_vec_i,
    output logic [NUM_HARTS-1:0]      irq_ready_o,
    input  logic [NUM_HARTS-1:0]      irq_en_i,
    input  logic                      instr_valid_i,
    input  logic [HID_W-1:0]          hart_id_i,
    input  logic [2:0]                op_i,
    input  logic                      br_taken_i,
    input  logic [PC_W-1:0]           cur_pc_i,
    input  logic [PC_W-1:0]           rs1_i,
    input  logic [PC_W-1:0]           imm_i,
    output logic [PC_W-1:0]           next_pc_o,
    output logic                      has_new_pc_o,
    output logic                      save_pc_o,
    output logic [PC_W-1:0]           reg_pc_o,
    output logic                      irq_taken_o,
    output logic                      mret_err_o,
    output logic [NUM_HARTS-1:0]      irq_pending_o,
    output logic [NUM_HARTS-1:0]      irq_ovf_o
);
    localparam int PTR_W = $clog2(IRQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SP_W  = $clog2(NEST_DEPTH) + 1;
    localparam int SI_W  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    localparam logic [2:0] OP_BR    = 3'd1;
    localparam logic [2:0] OP_JAL   = 3'd2;
    localparam logic [2:0] OP_JALR  = 3'd3;
    localparam logic [2:0] OP_AUIPC = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    logic [PC_W-1:0]  fifo_mem [NUM_HARTS][IRQ_DEPTH];
    logic [PC_W-1:0]  stk_mem  [NUM_HARTS][NEST_DEPTH];
    logic [PTR_W-1:0] rd_ptr   [NUM_HARTS];
    logic [PTR_W-1:0] wr_ptr   [NUM_HARTS];
    logic [CNT_W-1:0] cnt      [NUM_HARTS];
    logic [SP_W-1:0]  sp       [NUM_HARTS];

    logic [NUM_HARTS-1:0] fifo_full, fifo_nempty, hart_sel, push_en, pop_en;
    logic [PC_W-1:0]      seq_pc, br_pc, jalr_sum, base_pc, stk_top, fifo_head;
    logic                 hid_ok, is_mret, stk_empty_h, stk_full_h, irq_take, mret_pop;

    always_comb begin
        for (int k = 0; k < NUM_HARTS; k++) begin
            fifo_full[k]   = (cnt[k] == CNT_W'(IRQ_DEPTH));
            fifo_nempty[k] = (cnt[k] != '0);
        end
        hid_ok   = int'(hart_id_i) < NUM_HARTS;
        hart_sel = '0;
        if (hid_ok) hart_sel[hart_id_i] = 1'b1;
    end

    assign irq_ready_o   = ~fifo_full;
    assign irq_pending_o = fifo_nempty;

    always_comb begin
        seq_pc      = cur_pc_i + PC_W'(4);
        br_pc       = cur_pc_i + (imm_i << 1);
        jalr_sum    = rs1_i + imm_i;
        is_mret     = (op_i == OP_MRET);
        stk_empty_h = (sp[hart_id_i] == '0);
        stk_full_h  = (sp[hart_id_i] == SP_W'(NEST_DEPTH));
        stk_top     = stk_mem[hart_id_i][SI_W'(sp[hart_id_i] - SP_W'(1))];
        fifo_head   = fifo_mem[hart_id_i][rd_ptr[hart_id_i]];

        case (op_i)
            OP_BR:   base_pc = br_taken_i ? br_pc : seq_pc;
            OP_JAL:  base_pc = br_pc;
            OP_JALR: base_pc = {jalr_sum[PC_W-1:1], 1'b0};
            OP_MRET: base_pc = stk_empty_h ? seq_pc : stk_top;
            default: base_pc = seq_pc;
        endcase

        // The retiring instruction's target is what the trap handler returns to.
        irq_take = instr_valid_i && hid_ok && !is_mret && fifo_nempty[hart_id_i]
                   && irq_en_i[hart_id_i] && !stk_full_h;
        mret_pop = instr_valid_i && hid_ok && is_mret && !stk_empty_h;

        next_pc_o    = seq_pc;
        has_new_pc_o = 1'b0;
        save_pc_o    = 1'b0;
        reg_pc_o     = '0;
        irq_taken_o  = 1'b0;
        mret_err_o   = 1'b0;
        if (instr_valid_i) begin
            if (op_i == OP_JAL || op_i == OP_JALR) begin
                save_pc_o = 1'b1;
                reg_pc_o  = seq_pc;
            end else if (op_i == OP_AUIPC) begin
                save_pc_o = 1'b1;
                reg_pc_o  = cur_pc_i + imm_i;
            end
            if (irq_take) begin
                next_pc_o    = fifo_head;
                has_new_pc_o = 1'b1;
                irq_taken_o  = 1'b1;
            end else if (is_mret) begin
                if (mret_pop) begin
                    next_pc_o    = stk_top;
                    has_new_pc_o = 1'b1;
                end else begin
                    mret_err_o = 1'b1;
                end
            end else begin
                next_pc_o    = base_pc;
                has_new_pc_o = (base_pc != seq_pc);
            end
        end

        for (int k = 0; k < NUM_HARTS; k++) begin
            push_en[k] = irq_valid_i[k] && !fifo_full[k];
            pop_en[k]  = irq_take && hart_sel[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_HARTS; k++) begin
                rd_ptr[k]    <= '0;
                wr_ptr[k]    <= '0;
                cnt[k]       <= '0;
                sp[k]        <= '0;
                irq_ovf_o[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_HARTS; k++) begin
                if (push_en[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                if (pop_en[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                cnt[k] <= cnt[k] + CNT_W'(push_en[k]) - CNT_W'(pop_en[k]);
                if (irq_valid_i[k] && fifo_full[k]) irq_ovf_o[k] <= 1'b1;
                if (pop_en[k])
                    sp[k] <= sp[k] + SP_W'(1);
                else if (mret_pop && hart_sel[k])
                    sp[k] <= sp[k] - SP_W'(1);
            end
        end
    end

    // Storage arrays carry no reset; pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (push_en[k]) fifo_mem[k][wr_ptr[k]] <= irq_vec_i[k*PC_W +: PC_W];
            if (pop_en[k])  stk_mem[k][SI_W'(sp[k])] <= base_pc;
        end
    end

endmodule

// File: tb/tb_rv32_trap_pc_ctrl.sv
// Directed bench for rv32_trap_pc_ctrl: branch targets, IRQ latency, nesting,
// overflow, push/pop concurrency and mid-operation reset.
module tb_rv32_trap_pc_ctrl;
    localparam int NH = 8;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NH-1:0] irq_valid, irq_ready, irq_en, irq_pending, irq_ovf;
    logic [NH*W-1:0] irq_vec;
    logic          instr_valid, br_taken;
    logic [2:0]    hart_id, op;
    logic [W-1:0]  cur_pc, rs1, imm, next_pc, reg_pc;
    logic          has_new, save_pc, irq_taken, mret_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv32_trap_pc_ctrl #(.NUM_HARTS(NH), .PC_W(W), .IRQ_DEPTH(4), .NEST_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .irq_valid_i(irq_valid), .irq_vec_i(irq_vec), .irq_ready_o(irq_ready),
        .irq_en_i(irq_en), .instr_valid_i(instr_valid), .hart_id_i(hart_id),
        .op_i(op), .br_taken_i(br_taken), .cur_pc_i(cur_pc), .rs1_i(rs1), .imm_i(imm),
        .next_pc_o(next_pc), .has_new_pc_o(has_new), .save_pc_o(save_pc),
        .reg_pc_o(reg_pc), .irq_taken_o(irq_taken), .mret_err_o(mret_err),
        .irq_pending_o(irq_pending), .irq_ovf_o(irq_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        instr_valid = 1'b0; hart_id = '0; op = '0; br_taken = 1'b0;
        cur_pc = '0; rs1 = '0; imm = '0; irq_valid = '0; irq_vec = '0;
    endtask

    // Step to the next low phase: the previous drive has been latched at the posedge.
    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic exec(input int h, input logic [2:0] o, input logic [31:0] c,
                        input logic [31:0] r, input logic [31:0] i, input logic b);
        instr_valid = 1'b1; hart_id = 3'(h); op = o; cur_pc = c; rs1 = r; imm = i; br_taken = b;
    endtask

    task automatic push(input int h, input logic [31:0] v);
        tick();
        irq_valid[h] = 1'b1;
        irq_vec[h*W +: W] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        irq_en = '1;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(irq_ready), 32'hFF);
        check("rst_pending", 32'(irq_pending), 32'h0);
        check("rst_ovf", 32'(irq_ovf), 32'h0);

        // Plain control flow
        tick(); exec(0, 3'd1, 32'h100, 0, 32'h10, 1'b1); #1;
        check("br_taken_next", next_pc, 32'h120);
        check("br_taken_new", 32'(has_new), 1);
        check("br_taken_save", 32'(save_pc), 0);
        br_taken = 1'b0; #1;
        check("br_nt_next", next_pc, 32'h104);
        check("br_nt_new", 32'(has_new), 0);
        tick(); exec(0, 3'd3, 32'h100, 32'h203, 0, 1'b0); #1;
        check("jalr_next", next_pc, 32'h202);
        check("jalr_save", 32'(save_pc), 1);
        check("jalr_reg", reg_pc, 32'h104);
        tick(); exec(0, 3'd2, 32'h100, 0, 32'h10, 1'b0); #1;
        check("jal_next", next_pc, 32'h120);
        check("jal_reg", reg_pc, 32'h104);
        tick(); exec(0, 3'd4, 32'h100, 0, 32'h1000, 1'b0); #1;
        check("auipc_next", next_pc, 32'h104);
        check("auipc_reg", reg_pc, 32'h1100);
        check("auipc_new", 32'(has_new), 0);
        tick(); exec(0, 3'd6, 32'h100, 0, 32'h10, 1'b1); #1;
        check("op6_next", next_pc, 32'h104);
        check("op6_save", 32'(save_pc), 0);
        tick(); exec(0, 3'd2, 32'h100, 0, 32'h10, 1'b0); instr_valid = 1'b0; #1;
        check("novalid_next", next_pc, 32'h104);
        check("novalid_save", 32'(save_pc), 0);
        tick(); exec(0, 3'd2, 32'hFFFF_FFF0, 0, 32'h10, 1'b0); #1;
        check("wrap_next", next_pc, 32'h10);
        check("wrap_reg", reg_pc, 32'hFFFF_FFF4);

        // IRQ latency on hart 2
        push(2, 32'h800); exec(2, 3'd0, 32'h40, 0, 0, 1'b0); #1;
        check("lat_n_taken", 32'(irq_taken), 0);
        check("lat_n_next", next_pc, 32'h44);
        tick(); exec(2, 3'd0, 32'h40, 0, 0, 1'b0); #1;
        check("lat_n1_taken", 32'(irq_taken), 1);
        check("lat_n1_next", next_pc, 32'h800);
        check("lat_n1_new", 32'(has_new), 1);
        tick(); #1;
        check("lat_popped", 32'(irq_pending[2]), 0);
        tick(); exec(2, 3'd5, 32'h900, 0, 0, 1'b0); #1;
        check("lat_mret_next", next_pc, 32'h44);
        check("lat_mret_err", 32'(mret_err), 0);

        // Nesting on hart 4 with a two-entry return stack
        push(4, 32'hA00); push(4, 32'hB00); push(4, 32'hC00);
        tick(); exec(4, 3'd0, 32'h10, 0, 0, 1'b0); #1;
        check("nest_t1", next_pc, 32'hA00);
        tick(); exec(4, 3'd0, 32'hA00, 0, 0, 1'b0); #1;
        check("nest_t2", next_pc, 32'hB00);
        tick(); exec(4, 3'd0, 32'hB00, 0, 0, 1'b0); #1;
        check("nest_full_taken", 32'(irq_taken), 0);
        check("nest_full_next", next_pc, 32'hB04);
        check("nest_still_pend", 32'(irq_pending[4]), 1);
        tick(); exec(4, 3'd5, 32'hB04, 0, 0, 1'b0); #1;
        check("nest_mret1", next_pc, 32'hA04);
        tick(); exec(4, 3'd0, 32'hA04, 0, 0, 1'b0); #1;
        check("nest_t3", next_pc, 32'hC00);
        tick(); exec(4, 3'd5, 32'hC04, 0, 0, 1'b0); #1;
        check("nest_mret2", next_pc, 32'hA08);
        tick(); exec(4, 3'd5, 32'hA08, 0, 0, 1'b0); #1;
        check("nest_mret3", next_pc, 32'h14);
        tick(); exec(4, 3'd5, 32'h14, 0, 0, 1'b0); #1;
        check("nest_mret_err", 32'(mret_err), 1);

        // Overflow on hart 0
        for (int i = 0; i < 4; i++) push(0, 32'h1000 + 32'(i) * 32'h100);
        tick(); #1;
        check("ovf_ready_low", 32'(irq_ready[0]), 0);
        check("ovf_not_yet", 32'(irq_ovf[0]), 0);
        irq_valid[0] = 1'b1; irq_vec[W-1:0] = 32'h1400;
        tick(); #1;
        check("ovf_sticky", 32'(irq_ovf[0]), 1);
        for (int i = 0; i < 4; i++) begin
            tick(); exec(0, 3'd0, 32'h60, 0, 0, 1'b0); #1;
            check("ovf_fifo_order", next_pc, 32'h1000 + 32'(i) * 32'h100);
            tick(); exec(0, 3'd5, 32'h70, 0, 0, 1'b0); #1;
            check("ovf_ret", next_pc, 32'h64);
        end
        tick(); #1;
        check("ovf_drained", 32'(irq_pending[0]), 0);
        check("ovf_kept", 32'(irq_ovf[0]), 1);

        // Concurrent take and push on a full hart 1 FIFO
        for (int i = 0; i < 4; i++) push(1, 32'h2000 + 32'(i) * 32'h100);
        tick(); irq_en[1] = 1'b0; exec(1, 3'd0, 32'h50, 0, 0, 1'b0); #1;
        check("irq_dis_taken", 32'(irq_taken), 0);
        irq_en[1] = 1'b1;
        irq_valid[1] = 1'b1; irq_vec[W +: W] = 32'h2400; #1;
        check("conc_ready", 32'(irq_ready[1]), 0);
        check("conc_next", next_pc, 32'h2000);
        tick(); #1;
        check("conc_ready_after", 32'(irq_ready[1]), 1);
        check("conc_ovf", 32'(irq_ovf[1]), 1);
        tick(); exec(1, 3'd5, 32'h90, 0, 0, 1'b0); #1;
        check("conc_ret", next_pc, 32'h54);
        for (int i = 1; i < 4; i++) begin
            tick(); exec(1, 3'd0, 32'h50, 0, 0, 1'b0); #1;
            check("conc_order", next_pc, 32'h2000 + 32'(i) * 32'h100);
            tick(); exec(1, 3'd5, 32'h90, 0, 0, 1'b0); #1;
            check("conc_ret", next_pc, 32'h54);
        end
        tick(); #1;
        check("conc_count3", 32'(irq_pending[1]), 0);
        tick(); exec(1, 3'd5, 32'h90, 0, 0, 1'b0); #1;
        check("mret_empty_err", 32'(mret_err), 1);
        check("mret_empty_next", next_pc, 32'h94);
        check("mret_empty_new", 32'(has_new), 0);

        // Reset in the middle of activity on hart 3
        push(3, 32'h3000); push(3, 32'h3100); push(3, 32'h3200);
        tick(); exec(3, 3'd0, 32'h30, 0, 0, 1'b0); #1;
        check("rst_pre_take", next_pc, 32'h3000);
        tick(); rst_n = 1'b0; exec(3, 3'd0, 32'h30, 0, 0, 1'b0);
        irq_valid[3] = 1'b1; irq_vec[3*W +: W] = 32'h3300;
        tick(); rst_n = 1'b1; exec(3, 3'd5, 32'h30, 0, 0, 1'b0); #1;
        check("rst_mid_pending", 32'(irq_pending), 0);
        check("rst_mid_ready", 32'(irq_ready), 32'hFF);
        check("rst_mid_ovf", 32'(irq_ovf), 0);
        check("rst_mid_mret_err", 32'(mret_err), 1);
        check("rst_mid_next", next_pc, 32'h34);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32_trap_pc_ctrl.md
# rv32_trap_pc_ctrl

Parametrised next-PC and trap-redirect unit for the barrel-threaded pito core, successor to the single-queue next-PC logic. It computes the control-flow target of the instruction in the execute stage for hart `hart_id_i`. It also keeps, per hart, a FIFO of pending interrupt handler vectors and a LIFO of return PCs, so nested interrupts and `mret` resolve in order. Sits between decode/ALU and the fetch PC register file.

## Interface
Parameters:
- `NUM_HARTS`, 8, number of hardware threads (≥1).
- `PC_W`, 32, PC and data width.
- `IRQ_DEPTH`, 4, pending-vector FIFO entries per hart (power of 2, ≥2).
- `NEST_DEPTH`, 2, return-PC stack entries per hart (≥1).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `irq_valid_i` in NUM_HARTS: per-hart interrupt vector push request.
- `irq_vec_i` in NUM_HARTS×PC_W: per-hart handler vector.
- `irq_ready_o` out NUM_HARTS: FIFO of that hart not full.
- `irq_en_i` in NUM_HARTS: per-hart interrupt enable (from CSR mstatus.MIE).
- `instr_valid_i` in 1: an instruction for `hart_id_i` is in execute this cycle.
- `hart_id_i` in clog2(NUM_HARTS): owning hart.
- `op_i` in 3: 0 other, 1 branch, 2 jal, 3 jalr, 4 auipc, 5 mret; 6–7 treated as 0.
- `br_taken_i` in 1: ALU branch result.
- `cur_pc_i`, `rs1_i`, `imm_i` in PC_W each.
- `next_pc_o` out PC_W: PC to fetch next for `hart_id_i`.
- `has_new_pc_o` out 1: `next_pc_o` ≠ sequential PC (`cur_pc_i`+4).
- `save_pc_o` out 1: write `reg_pc_o` to rd.
- `reg_pc_o` out PC_W: value for rd.
- `irq_taken_o` out 1: trap redirect taken this cycle.
- `mret_err_o` out 1: mret with empty return stack.
- `irq_pending_o` out NUM_HARTS: FIFO non-empty.
- `irq_ovf_o` out NUM_HARTS: sticky overflow, cleared only by reset.

## Operation
- All PC arithmetic is modulo 2^PC_W.
- Base target, combinational:
  - branch: `cur+(imm<<1)` if `br_taken_i`, else `cur+4`.
  - jal: `cur+(imm<<1)`.
  - jalr: `(rs1+imm)&~1`.
  - mret: stack top.
  - other and auipc: `cur+4`.
- `save_pc_o`/`reg_pc_o`:
  - jal, jalr: 1 / `cur+4`.
  - auipc: 1 / `cur+imm`.
  - otherwise: 0 / 0.
  - These do not depend on the interrupt decision.
- Interrupt take for hart h = `hart_id_i`, when all hold: `instr_valid_i`, op ≠ mret, FIFO[h] non-empty, `irq_en_i[h]`, stack[h] not full. On take:
  - `next_pc_o` = FIFO[h] head.
  - Pop the FIFO head.
  - Push the base target onto stack[h] (the instruction retires, the trap follows).
  - `irq_taken_o`=1, `has_new_pc_o`=1.
- mret:
  - Stack non-empty: pop, `next_pc_o` = popped value, `has_new_pc_o`=1.
  - Stack empty: `next_pc_o`=`cur+4`, `has_new_pc_o`=0, `mret_err_o`=1, no state change.
  - A pending interrupt is never taken in the same cycle as mret.
- Push side: `irq_valid_i[k]` with FIFO[k] not full writes at the tail. If the FIFO is full, the vector is dropped and `irq_ovf_o[k]` is set.
- Simultaneous push and pop on the same hart:
  - Both occur; count unchanged.
  - When full, the push is still refused: `irq_ready_o` reflects the registered count, with no same-cycle pass-through.
- `instr_valid_i`=0: `next_pc_o`=`cur+4`; all strobes 0; no pops or stack changes. Pushes still occur.
- Per hart state: FIFO rd/wr pointers (clog2(IRQ_DEPTH) bits, natural wrap) plus a count (clog2(IRQ_DEPTH)+1 bits); stack pointer (clog2(NEST_DEPTH)+1 bits).

## Timing
- Next-PC path is combinational from inputs and registered state, same cycle.
- All state updates on posedge `clk`.
- A vector pushed in cycle N is visible as pending/takeable from cycle N+1; there is no bypass.
- Reset (synchronous, any cycle, including mid-push or mid-trap):
  - All pointers, counts and `irq_ovf_o` go to 0.
  - FIFO/stack data is don't-care.
  - Outputs after reset: `irq_ready_o`=all 1, `irq_pending_o`=0, `irq_ovf_o`=0. Combinational outputs follow the inputs, with empty state.

## Test plan
- Branch: `cur=0x100, imm=0x10`. Taken gives `next=0x120, has_new=1`. Not taken gives `next=0x104, has_new=0`. jalr with `rs1=0x203, imm=0` gives `next=0x202, save=1, reg=cur+4`.
- IRQ latency: push `0x800` to hart 2 at cycle N, with hart 2 executing op=other at `cur=0x40` in cycles N and N+1.
  - Cycle N: no take.
  - Cycle N+1: `next=0x800, irq_taken=1`; stack holds `0x44`.
  - Later mret on hart 2 gives `next=0x44`.
- Nesting, NEST_DEPTH=2: take three queued vectors back-to-back. The third stays pending and is taken only after one mret. mret order returns the saved PCs LIFO.
- Overflow, IRQ_DEPTH=4: five pushes to hart 0 with no execution. `irq_ready_o[0]` drops after the 4th, the 5th is dropped, `irq_ovf_o[0]=1`. The four vectors are then taken in FIFO order.
- Concurrency: full FIFO on hart 1, same-cycle take and push. The push is refused and the count becomes 3. mret on an empty stack gives `mret_err_o=1, next=cur+4`.
- Reset mid-operation: assert `rst_n=0` with hart 3 holding 2 pending vectors and 1 stack entry. The next cycle shows `irq_pending_o=0`, `irq_ready_o=all 1`, and mret reports an error.
